// File: rtl/contador_mod_updown_pkg.sv
// Shared encodings and parameter-legality helper for the modulo up/down
// counter family.
package contador_mod_updown_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  function automatic bit params_ok(
    input int w,
    input int m,
    input int r
  );
    if (w < 1 || w > 30) return 1'b0;
    if (m < 2 || m > (1 << w)) return 1'b0;
    if (r < 0 || r >= m) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/contador_tc.sv
// Terminal-count detector: last value when counting up, zero when
// counting down.
module contador_tc
  import contador_mod_updown_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int MODULO = 100
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic             tc
);

  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 1);

  logic [WIDTH:0] qx;

  assign qx = {1'b0, q};
  assign tc = (up == DIR_UP) ? (qx == LAST) : (qx == '0);

endmodule

// File: rtl/contador_mod_updown.sv
// Parametrised modulo-N up/down counter with load, preset, one-shot
// mode and a carry output for cascading.
module contador_mod_updown
  import contador_mod_updown_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int MODULO    = 100,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             done
);

  if (!params_ok(WIDTH, MODULO, RESET_VAL)) begin : g_param_err
    $error("contador_mod_updown: illegal WIDTH/MODULO/RESET_VAL");
  end

  // One spare bit so MODULO == 2**WIDTH needs no special casing.
  localparam logic [WIDTH:0] LAST  = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  logic [WIDTH:0] qx, dx;
  logic [WIDTH:0] load_x, step_x, wrap_x, q_nx;

  contador_tc #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_tc (
    .q  (q_q),
    .up (up),
    .tc (tc)
  );

  assign qx     = {1'b0, q_q};
  assign dx     = {1'b0, d};
  assign load_x = (dx >= MOD_X) ? LAST : dx;
  assign step_x = (up == DIR_UP) ? qx + ONE_X : qx - ONE_X;
  assign wrap_x = (up == DIR_UP) ? '0 : LAST;

  always_comb begin
    q_nx   = qx;
    done_d = done_q;
    priority case (1'b1)
      pr: begin
        q_nx   = LAST;
        done_d = 1'b0;
      end
      ld: begin
        q_nx   = load_x;
        done_d = 1'b0;
      end
      (en && !done_q): begin
        if (!tc) begin
          q_nx = step_x;
        end else if (mode == MODE_WRAP) begin
          q_nx = wrap_x;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign q_d = WIDTH'(q_nx);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q    <= RST;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign done = done_q;
  assign co   = tc & en & ~done_q;

endmodule

// File: tb/tb_contador_mod_updown.sv
// Bench for contador_mod_updown: constant vector table, hand sequences
// and random stimulus against an arithmetic reference model.
module tb_contador_mod_updown;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, pr, ld, en, up, mode;
  logic [6:0] d;

  logic [6:0] q0;
  logic [3:0] q1, q2;
  logic       tc0, tc1, tc2, co0, co1, co2, dn0, dn1, dn2;

  contador_mod_updown #(.WIDTH(7), .MODULO(100), .RESET_VAL(0)) u0 (
    .clk(clk), .clr(clr), .pr(pr), .ld(ld), .d(d), .en(en), .up(up),
    .mode(mode), .q(q0), .tc(tc0), .co(co0), .done(dn0)
  );

  contador_mod_updown #(.WIDTH(4), .MODULO(16), .RESET_VAL(0)) u1 (
    .clk(clk), .clr(clr), .pr(pr), .ld(ld), .d(d[3:0]), .en(en), .up(up),
    .mode(mode), .q(q1), .tc(tc1), .co(co1), .done(dn1)
  );

  contador_mod_updown #(.WIDTH(4), .MODULO(10), .RESET_VAL(9)) u2 (
    .clk(clk), .clr(clr), .pr(pr), .ld(ld), .d(d[3:0]), .en(en), .up(up),
    .mode(mode), .q(q2), .tc(tc2), .co(co2), .done(dn2)
  );

  int checks = 0;
  int errors = 0;

  int MM[3] = '{100, 16, 10};
  int RV[3] = '{0, 0, 9};
  int mq[3];
  int md[3];

  typedef struct {
    logic       pr, ld, en, up, mode;
    logic [6:0] d;
    int         q;
    logic       done, tc, co;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = RV[i];
      md[i] = 0;
    end
  endtask

  task automatic model_step();
    int dv, m;
    bit at;
    for (int i = 0; i < 3; i++) begin
      m  = MM[i];
      dv = (i == 0) ? int'(d) : int'(d[3:0]);
      if (pr) begin
        mq[i] = m - 1;
        md[i] = 0;
      end else if (ld) begin
        mq[i] = (dv >= m) ? m - 1 : dv;
        md[i] = 0;
      end else if (en && md[i] == 0) begin
        at = up ? (mq[i] == m - 1) : (mq[i] == 0);
        if (at && mode) md[i] = 1;
        else mq[i] = up ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int gq, gd, gt, gc, et, ec;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin gq = q0; gd = dn0; gt = tc0; gc = co0; end
        1: begin gq = q1; gd = dn1; gt = tc1; gc = co1; end
        default: begin gq = q2; gd = dn2; gt = tc2; gc = co2; end
      endcase
      et = up ? int'(mq[i] == MM[i] - 1) : int'(mq[i] == 0);
      ec = (et != 0 && en && md[i] == 0) ? 1 : 0;
      chk($sformatf("%s u%0d q", tag, i), gq, mq[i]);
      chk($sformatf("%s u%0d done", tag, i), gd, md[i]);
      chk($sformatf("%s u%0d tc", tag, i), gt, et);
      chk($sformatf("%s u%0d co", tag, i), gc, ec);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (clr) model_step();
    #1;
    check_all(tag);
  endtask

  // Called #1 after an edge: pulls clr low between edges.
  task automatic async_reset(input string tag);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    clr = 1'b1;
  endtask

  task automatic set_in(input logic p, input logic l, input logic e,
                        input logic u, input logic m, input logic [6:0] dd);
    pr = p; ld = l; en = e; up = u; mode = m; d = dd;
  endtask

  function automatic vec_t mk(input logic p, input logic l, input logic e,
                              input logic u, input logic m,
                              input logic [6:0] dd, input int eq,
                              input logic edn, input logic etc,
                              input logic eco);
    vec_t v;
    v.pr = p; v.ld = l; v.en = e; v.up = u; v.mode = m; v.d = dd;
    v.q = eq; v.done = edn; v.tc = etc; v.co = eco;
    return v;
  endfunction

  initial begin
    // down count after reset
    tbl.push_back(mk(0, 0, 1, 0, 0, 7'd0, 99, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7'd0, 98, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7'd0, 97, 0, 0, 0));
    // up wrap
    tbl.push_back(mk(0, 1, 0, 1, 0, 7'd97, 97, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7'd0, 98, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7'd0, 99, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7'd0, 1, 0, 0, 0));
    // one-shot down
    tbl.push_back(mk(0, 1, 0, 0, 1, 7'd3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 7'd0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 7'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 7'd0, 0, 0, 1, 1));
    for (int i = 0; i < 11; i++)
      tbl.push_back(mk(0, 0, 1, 0, 1, 7'd0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 7'd5, 5, 0, 0, 0));
    // priority and clamp
    tbl.push_back(mk(1, 1, 0, 0, 0, 7'd10, 99, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 7'd120, 99, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 7'd0, 99, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 7'd42, 42, 0, 0, 0));

    clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 7'd0);
    model_reset();
    #20;
    chk("reset q", q0, 0);
    chk("reset done", dn0, 0);
    chk("reset tc", tc0, 1);
    chk("reset co en0", co0, 0);
    clr = 1'b1;
    en  = 1'b1;
    #1;
    chk("reset co en1", co0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].pr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].mode,
             tbl[i].d);
      tick("vec");
      chk($sformatf("vec%0d q", i), q0, tbl[i].q);
      chk($sformatf("vec%0d done", i), dn0, tbl[i].done);
      chk($sformatf("vec%0d tc", i), tc0, tbl[i].tc);
      chk($sformatf("vec%0d co", i), co0, tbl[i].co);
    end

    // async reset with q at 42, no clock edge involved
    set_in(0, 0, 0, 1, 0, 7'd0);
    async_reset("async");
    chk("async q", q0, 0);
    chk("async done", dn0, 0);
    chk("async u2 q", q2, 9);

    // 4-bit full-range wrap
    set_in(0, 1, 0, 1, 0, 7'd14);
    tick("sw16");
    set_in(0, 0, 1, 1, 0, 7'd0);
    tick("sw16");
    chk("sw16 q15", q1, 15);
    chk("sw16 tc", tc1, 1);
    tick("sw16");
    chk("sw16 wrap", q1, 0);

    // modulo-10 down count to zero
    set_in(0, 1, 0, 0, 0, 7'd9);
    tick("sw10");
    chk("sw10 load", q2, 9);
    set_in(0, 0, 1, 0, 0, 7'd0);
    for (int i = 0; i < 9; i++) tick("sw10");
    chk("sw10 zero", q2, 0);
    chk("sw10 tc", tc2, 1);

    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom % 25) == 0, ($urandom % 15) == 0,
             ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0,
             7'($urandom));
      if (($urandom % 120) == 0) async_reset("rnd_rst");
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
